// File: rtl/bubsysrom_mem_pkg.sv
// Shared types and helpers for the BubSysROM dual-port RAM with clear sequencer.
// The lane-merge helper works on a maximum-width word so that any DW/LW pair can use it.
package bubsysrom_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RDW_READFIRST  = 0;
    localparam int RDW_WRITEFIRST = 1;

    localparam int MAX_DW = 64;

    // Bit i takes new_w when its lane (i / lw) is enabled, otherwise old_w.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_DW-1:0] be,
        input int                lw
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_DW; i++) begin
            if (be[i / lw]) begin
                res[i] = new_w[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bubsysrom_mem_clr_seq.sv
// Clear sequencer: sweeps CLRVAL through every word after reset or on request.
// state    | meaning
// ST_CLEAR | sweeping cnt through 0..2**AW-1, ports locked out, busy=1
// ST_READY | normal dual-port operation, i_clr starts a new sweep
module bubsysrom_mem_clr_seq
    import bubsysrom_mem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            ST_READY: begin
                if (i_clr) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                end
            end
        endcase
    end

    assign o_busy     = busy_q;
    assign o_clr_we   = (state_q == ST_CLEAR);
    assign o_clr_addr = cnt_q;

endmodule

// File: rtl/bubsysrom_dpram_clr.sv
// True dual-port RAM with per-lane enables, selectable cross-port read-during-write
// behaviour and a clear sweep that owns the write path while o_BUSY is high.
module bubsysrom_dpram_clr
    import bubsysrom_mem_pkg::*;
#(
    parameter int             AW      = 10,
    parameter int             DW      = 8,
    parameter int             LW      = 8,
    parameter int             RDWMODE = 0,
    parameter logic [DW-1:0]  CLRVAL  = '0
) (
    input  logic               i_MCLK,
    input  logic               i_RST_n,
    input  logic               i_CLR,
    output logic               o_BUSY,
    input  logic [AW-1:0]      i_A_ADDR,
    input  logic [DW-1:0]      i_A_DIN,
    input  logic [DW/LW-1:0]   i_A_BE,
    input  logic               i_A_RD,
    input  logic               i_A_WR,
    output logic [DW-1:0]      o_A_DOUT,
    input  logic [AW-1:0]      i_B_ADDR,
    input  logic [DW-1:0]      i_B_DIN,
    input  logic [DW/LW-1:0]   i_B_BE,
    input  logic               i_B_RD,
    input  logic               i_B_WR,
    output logic [DW-1:0]      o_B_DOUT
);

    localparam int DEPTH = 1 << AW;

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          busy;

    bubsysrom_mem_clr_seq #(.AW(AW)) u_clr_seq (
        .i_clk      (i_MCLK),
        .i_rst_n    (i_RST_n),
        .i_clr      (i_CLR),
        .o_busy     (busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    logic [DW-1:0] mem_q [0:DEPTH-1];

    logic          port_en;
    logic          a_wr_en, b_wr_en, a_rd_en, b_rd_en;
    logic [DW-1:0] a_old, b_old, a_post, b_post;
    logic [DW-1:0] a_rd_word, b_rd_word;
    logic [DW-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;

    // Ports are locked out during the sweep and during reset cycles.
    assign port_en = !busy && i_RST_n;
    assign a_wr_en = port_en && i_A_WR;
    assign b_wr_en = port_en && i_B_WR;
    assign a_rd_en = port_en && i_A_RD && !i_A_WR;
    assign b_rd_en = port_en && i_B_RD && !i_B_WR;

    // Post-write word at each port's address: B's lanes first, then A's on top,
    // so A wins on lanes enabled by both.
    always_comb begin
        a_old  = mem_q[i_A_ADDR];
        b_old  = mem_q[i_B_ADDR];
        a_post = a_old;
        b_post = b_old;
        if (b_wr_en && (i_B_ADDR == i_A_ADDR)) begin
            a_post = DW'(lane_merge(MAX_DW'(a_post), MAX_DW'(i_B_DIN), MAX_DW'(i_B_BE), LW));
        end
        if (a_wr_en) begin
            a_post = DW'(lane_merge(MAX_DW'(a_post), MAX_DW'(i_A_DIN), MAX_DW'(i_A_BE), LW));
        end
        if (b_wr_en) begin
            b_post = DW'(lane_merge(MAX_DW'(b_post), MAX_DW'(i_B_DIN), MAX_DW'(i_B_BE), LW));
        end
        if (a_wr_en && (i_A_ADDR == i_B_ADDR)) begin
            b_post = DW'(lane_merge(MAX_DW'(b_post), MAX_DW'(i_A_DIN), MAX_DW'(i_A_BE), LW));
        end
    end

    always_comb begin
        a_rd_word = (RDWMODE == RDW_WRITEFIRST) ? a_post : a_old;
        b_rd_word = (RDWMODE == RDW_WRITEFIRST) ? b_post : b_old;
        a_dout_d  = a_dout_q;
        b_dout_d  = b_dout_q;
        if (a_rd_en) begin
            a_dout_d = a_rd_word;
        end
        if (b_rd_en) begin
            b_dout_d = b_rd_word;
        end
    end

    // Same-address dual writes store identical merged words from both ports.
    always_ff @(posedge i_MCLK) begin
        if (clr_we) begin
            mem_q[clr_addr] <= CLRVAL;
        end else begin
            if (a_wr_en) begin
                mem_q[i_A_ADDR] <= a_post;
            end
            if (b_wr_en) begin
                mem_q[i_B_ADDR] <= b_post;
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    assign o_BUSY   = busy;
    assign o_A_DOUT = a_dout_q;
    assign o_B_DOUT = b_dout_q;

endmodule

// File: tb/tb_bubsysrom_dpram_clr.sv
// Bench for bubsysrom_dpram_clr: a read-first and a write-first instance share stimulus;
// reads queue expected words that a monitor pops one cycle after each accepted read.
module tb_bubsysrom_dpram_clr;

    localparam int            AW  = 4;
    localparam int            DW  = 16;
    localparam int            LW  = 8;
    localparam logic [15:0]   CLR = 16'hC35A;

    logic          clk = 1'b0;
    logic          rst_n, clr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic [1:0]    a_be, b_be;
    logic          a_rd, a_wr, b_rd, b_wr;
    logic          busy0, busy1;
    logic [DW-1:0] a_dout0, b_dout0, a_dout1, b_dout1;

    always #5 clk = ~clk;

    bubsysrom_dpram_clr #(.AW(AW), .DW(DW), .LW(LW), .RDWMODE(0), .CLRVAL(CLR)) dut0 (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_CLR(clr), .o_BUSY(busy0),
        .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_BE(a_be), .i_A_RD(a_rd), .i_A_WR(a_wr),
        .o_A_DOUT(a_dout0),
        .i_B_ADDR(b_addr), .i_B_DIN(b_din), .i_B_BE(b_be), .i_B_RD(b_rd), .i_B_WR(b_wr),
        .o_B_DOUT(b_dout0)
    );

    bubsysrom_dpram_clr #(.AW(AW), .DW(DW), .LW(LW), .RDWMODE(1), .CLRVAL(CLR)) dut1 (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_CLR(clr), .o_BUSY(busy1),
        .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_BE(a_be), .i_A_RD(a_rd), .i_A_WR(a_wr),
        .o_A_DOUT(a_dout1),
        .i_B_ADDR(b_addr), .i_B_DIN(b_din), .i_B_BE(b_be), .i_B_RD(b_rd), .i_B_WR(b_wr),
        .o_B_DOUT(b_dout1)
    );

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        string       nm;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Monitor: a read accepted at an edge presents data right after that edge.
    always @(posedge clk) begin
        logic fa, fb;
        exp_t e;
        fa = a_rd && !a_wr && rst_n && !busy0;
        fb = b_rd && !b_wr && rst_n && !busy0;
        #1;
        if (fa) begin
            if (qa.size() == 0) begin
                n_chk++;
                $display("FAIL a_unexpected_read: got %h want none", a_dout0);
            end else begin
                e = qa.pop_front();
                check({e.nm, "_a_rf"}, a_dout0, e.e0);
                check({e.nm, "_a_wf"}, a_dout1, e.e1);
            end
        end
        if (fb) begin
            if (qb.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_read: got %h want none", b_dout0);
            end else begin
                e = qb.pop_front();
                check({e.nm, "_b_rf"}, b_dout0, e.e0);
                check({e.nm, "_b_wf"}, b_dout1, e.e1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0; clr = 0;
    endtask

    task automatic wr_a(input logic [AW-1:0] ad, input logic [15:0] d, input logic [1:0] be);
        a_addr = ad; a_din = d; a_be = be; a_wr = 1; tick(); a_wr = 0;
    endtask

    task automatic wr_b(input logic [AW-1:0] ad, input logic [15:0] d, input logic [1:0] be);
        b_addr = ad; b_din = d; b_be = be; b_wr = 1; tick(); b_wr = 0;
    endtask

    task automatic rd_a(input logic [AW-1:0] ad, input logic [15:0] e0, input logic [15:0] e1,
                        input string nm);
        a_addr = ad; a_rd = 1; qa.push_back(exp_t'{e0, e1, nm}); tick(); a_rd = 0;
    endtask

    task automatic rd_b(input logic [AW-1:0] ad, input logic [15:0] e0, input logic [15:0] e1,
                        input string nm);
        b_addr = ad; b_rd = 1; qb.push_back(exp_t'{e0, e1, nm}); tick(); b_rd = 0;
    endtask

    // Counts edges until BUSY drops (bounded); DOUTs must stay 0 meanwhile.
    task automatic sweep(input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
            if (busy0) begin
                check({nm, "_dout_a_sweep"}, a_dout0, 16'h0000);
                check({nm, "_dout_b_sweep"}, b_dout1, 16'h0000);
            end
        end while (busy0 && n < 40);
        check({nm, "_busy_cycles"}, 16'(n), 16'd16);
        check({nm, "_busy1_low"}, 16'(busy1), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; idle();
        a_addr = 0; b_addr = 0; a_din = 0; b_din = 0; a_be = 2'b11; b_be = 2'b11;
        repeat (3) tick();
        check("rst_busy", 16'(busy0), 16'd1);
        check("rst_a_dout", a_dout0, 16'h0000);
        check("rst_b_dout", b_dout1, 16'h0000);

        // Release reset with a write and a read pending: both must be ignored.
        rst_n = 1;
        a_addr = 3; a_din = 16'h00A5; a_be = 2'b11; a_wr = 1;
        b_addr = 0; b_rd = 1;
        sweep("init");
        idle();

        for (int i = 0; i < 16; i++) rd_a(AW'(i), CLR, CLR, "clr_fill");
        rd_b(3, CLR, CLR, "busy_wr_dropped");

        // Lane enables across two writes.
        wr_a(2, 16'h1234, 2'b11);
        wr_b(2, 16'hABCD, 2'b01);
        rd_a(2, 16'h12CD, 16'h12CD, "lane_merge");

        // Simultaneous writes to one address: A wins enabled lanes.
        a_addr = 5; a_din = 16'h0011; a_be = 2'b11; a_wr = 1;
        b_addr = 5; b_din = 16'h0022; b_be = 2'b11; b_wr = 1;
        tick(); idle();
        rd_b(5, 16'h0011, 16'h0011, "dual_wr_full");
        a_addr = 6; a_din = 16'h1111; a_be = 2'b01; a_wr = 1;
        b_addr = 6; b_din = 16'h2222; b_be = 2'b11; b_wr = 1;
        tick(); idle();
        rd_a(6, 16'h2211, 16'h2211, "dual_wr_lane");

        // Cross-port read during write.
        wr_a(7, 16'h0000, 2'b11);
        a_addr = 7; a_din = 16'h005A; a_be = 2'b11; a_wr = 1;
        b_addr = 7; b_rd = 1; qb.push_back(exp_t'{16'h0000, 16'h005A, "rdw_full"});
        tick(); idle();
        rd_a(7, 16'h005A, 16'h005A, "rdw_full_after");
        wr_b(8, 16'h0000, 2'b11);
        a_addr = 8; a_din = 16'hBEEF; a_be = 2'b01; a_wr = 1;
        b_addr = 8; b_rd = 1; qb.push_back(exp_t'{16'h0000, 16'h00EF, "rdw_lane"});
        tick(); idle();
        rd_a(8, 16'h00EF, 16'h00EF, "rdw_lane_after");
        b_addr = 9; b_din = 16'h3300; b_be = 2'b10; b_wr = 1;
        a_addr = 9; a_rd = 1; qa.push_back(exp_t'{CLR, 16'h335A, "rdw_b_to_a"});
        tick(); idle();

        // Write beats read on the same port: DOUT holds the previous read.
        a_addr = 10; a_din = 16'h7777; a_be = 2'b11; a_rd = 1; a_wr = 1;
        tick(); idle();
        check("wr_prio_hold_rf", a_dout0, CLR);
        check("wr_prio_hold_wf", a_dout1, 16'h335A);
        rd_a(10, 16'h7777, 16'h7777, "wr_prio_written");

        // Fill, request a clear, then reset mid-sweep.
        for (int i = 0; i < 16; i++) wr_a(AW'(i), 16'h0100 + 16'(i), 2'b11);
        clr = 1; tick(); clr = 0;
        check("clr_busy_rise", 16'(busy0), 16'd1);
        repeat (4) tick();
        rst_n = 0; tick();
        check("mid_rst_busy", 16'(busy0), 16'd1);
        check("mid_rst_dout", a_dout0, 16'h0000);
        rst_n = 1;
        clr = 1;
        sweep("restart");
        idle();
        for (int i = 0; i < 16; i++) rd_b(AW'(i), CLR, CLR, "reclear");

        repeat (3) tick();
        check("qa_drained", 16'(qa.size()), 16'd0);
        check("qb_drained", 16'(qb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
